// File: rtl/axi_reg_bank.sv
// Parametrised AXI slave register bank: single-beat writes and reads, ID echo, flat register output.
// Optional macro AXI_REG_BANK_SLVERR_EN enables range checking with SLVERR responses.
module axi_reg_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [ID_W-1:0]              awid_i,
  input  logic [ADDR_W-1:0]            awaddr_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [DATA_W/8-1:0]          wstrb_i,
  input  logic                         wlast_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [ID_W-1:0]              bid_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [ID_W-1:0]              arid_i,
  input  logic [ADDR_W-1:0]            araddr_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [ID_W-1:0]              rid_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rlast_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // write channel state
  wstate_t             r_wstate, w_wstate_nxt;
  logic                r_aw_held, w_aw_held_nxt;
  logic                r_w_held, w_w_held_nxt;
  logic                r_awready, w_awready_nxt;
  logic                r_wready, w_wready_nxt;
  logic                r_bvalid, w_bvalid_nxt;
  logic [ID_W-1:0]     r_bid, w_bid_nxt;
  logic [1:0]          r_bresp, w_bresp_nxt;
  logic [ID_W-1:0]     r_awid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;

  // read channel state
  rstate_t             r_rstate, w_rstate_nxt;
  logic                r_arready, w_arready_nxt;
  logic                r_rvalid, w_rvalid_nxt;
  logic                r_rlast, w_rlast_nxt;
  logic [ID_W-1:0]     r_rid, w_rid_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic [1:0]          r_rresp, w_rresp_nxt;

  logic                w_aw_hs, w_w_hs, w_ar_hs;
  logic                w_aw_have, w_w_have, w_commit;
  logic [ID_W-1:0]     w_cur_awid;
  logic [ADDR_W-1:0]   w_cur_awaddr;
  logic [DATA_W-1:0]   w_cur_wdata;
  logic [STRB_W-1:0]   w_cur_wstrb;
  logic [IDX_W-1:0]    w_wr_idx, w_rd_idx;
  logic                w_wr_oor, w_rd_oor;
  logic                w_unused_ok;

  // A beat arriving this cycle is used directly so the commit lands on the last handshake edge
  assign w_aw_hs      = awvalid_i & r_awready;
  assign w_w_hs       = wvalid_i & r_wready;
  assign w_ar_hs      = arvalid_i & r_arready;
  assign w_aw_have    = r_aw_held | w_aw_hs;
  assign w_w_have     = r_w_held | w_w_hs;
  assign w_cur_awid   = r_aw_held ? r_awid   : awid_i;
  assign w_cur_awaddr = r_aw_held ? r_awaddr : awaddr_i;
  assign w_cur_wdata  = r_w_held  ? r_wdata  : wdata_i;
  assign w_cur_wstrb  = r_w_held  ? r_wstrb  : wstrb_i;
  assign w_wr_idx     = w_cur_awaddr[LSB +: IDX_W];
  assign w_rd_idx     = araddr_i[LSB +: IDX_W];

`ifdef AXI_REG_BANK_SLVERR_EN
  localparam logic [ADDR_W-1:0] L_RANGE = ADDR_W'(NUM_REGS * STRB_W);
  assign w_wr_oor = (w_cur_awaddr >= L_RANGE);
  assign w_rd_oor = (araddr_i >= L_RANGE);
`else
  assign w_wr_oor = 1'b0;
  assign w_rd_oor = 1'b0;
`endif

  // Byte offset bits and wlast carry no information for single-beat transfers
  assign w_unused_ok = &{1'b0, wlast_i, w_cur_awaddr, araddr_i};

  // Write FSM next-state and outputs
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_held_nxt = r_aw_held | w_aw_hs;
    w_w_held_nxt  = r_w_held | w_w_hs;
    w_commit      = 1'b0;
    w_bvalid_nxt  = r_bvalid;
    w_bid_nxt     = r_bid;
    w_bresp_nxt   = r_bresp;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_have && w_w_have) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
          w_bvalid_nxt = 1'b1;
          w_bid_nxt    = w_cur_awid;
          w_bresp_nxt  = w_wr_oor ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          w_wstate_nxt  = W_IDLE;
          w_bvalid_nxt  = 1'b0;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    w_awready_nxt = (w_wstate_nxt == W_IDLE) && !w_aw_held_nxt;
    w_wready_nxt  = (w_wstate_nxt == W_IDLE) && !w_w_held_nxt;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bid     <= w_bid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // AW/W holding registers
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_awid   <= '0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awid   <= awid_i;
        r_awaddr <= awaddr_i;
      end
      if (w_w_hs) begin
        r_wdata <= wdata_i;
        r_wstrb <= wstrb_i;
      end
    end
  end

  // Register storage with byte-strobe commit
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int k = 0; k < int'(NUM_REGS); k++) r_regs[k] <= '0;
    end else if (w_commit && !w_wr_oor) begin
      for (int j = 0; j < int'(STRB_W); j++) begin
        if (w_cur_wstrb[j]) r_regs[w_wr_idx][j*8 +: 8] <= w_cur_wdata[j*8 +: 8];
      end
    end
  end

  // Read FSM next-state and outputs; data sampled before any same-edge write lands
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rvalid_nxt = r_rvalid;
    w_rlast_nxt  = r_rlast;
    w_rid_nxt    = r_rid;
    w_rdata_nxt  = r_rdata;
    w_rresp_nxt  = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_DATA;
          w_rvalid_nxt = 1'b1;
          w_rlast_nxt  = 1'b1;
          w_rid_nxt    = arid_i;
          w_rdata_nxt  = w_rd_oor ? '0 : r_regs[w_rd_idx];
          w_rresp_nxt  = w_rd_oor ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA: begin
        if (rready_i) begin
          w_rstate_nxt = R_IDLE;
          w_rvalid_nxt = 1'b0;
          w_rlast_nxt  = 1'b0;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
    w_arready_nxt = (w_rstate_nxt == R_IDLE);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      r_rid     <= w_rid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  assign awready_o = r_awready;
  assign wready_o  = r_wready;
  assign bvalid_o  = r_bvalid;
  assign bid_o     = r_bid;
  assign bresp_o   = r_bresp;
  assign arready_o = r_arready;
  assign rvalid_o  = r_rvalid;
  assign rlast_o   = r_rlast;
  assign rid_o     = r_rid;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;

  for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_flat
    assign regs_o[k*DATA_W +: DATA_W] = r_regs[k];
  end

endmodule

// File: tb/tb_axi_reg_bank.sv
// Scoreboard bench for axi_reg_bank: directed scenarios plus randomized traffic against an array model.
`timescale 1ns/1ps
module tb_axi_reg_bank;
  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 8;
  localparam int unsigned IW  = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int          TMO = 200;
`ifdef AXI_REG_BANK_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset;
  logic [IW-1:0] awid_i, arid_i, bid_o, rid_o;
  logic [AW-1:0] awaddr_i, araddr_i;
  logic awvalid_i, awready_o, wvalid_i, wready_o, wlast_i;
  logic [DW-1:0] wdata_i, rdata_o;
  logic [SW-1:0] wstrb_i;
  logic [1:0] bresp_o, rresp_o;
  logic bvalid_o, arvalid_i, arready_o, rlast_o, rvalid_o;
  logic bready_i = 1'b0;
  logic rready_i = 1'b0;
  logic [NR*DW-1:0] regs_o;

  always #5 clk = ~clk;

  axi_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .ID_W(IW), .ADDR_W(AW)) dut (
    .clk(clk), .areset(areset),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .regs_o(regs_o)
  );

  typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mdl [NR];
  bit   rand_mode = 1'b0;
  logic bready_fix = 1'b1;
  logic rready_fix = 1'b1;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic bit addr_oor(logic [AW-1:0] a);
    return a >= AW'(NR * SW);
  endfunction

  function automatic int addr_idx(logic [AW-1:0] a);
    return int'((a / AW'(SW)) % AW'(NR));
  endfunction

  function automatic void model_write(logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    if (SLV && addr_oor(a)) return;
    for (int j = 0; j < int'(SW); j++)
      if (s[j]) mdl[addr_idx(a)][j*8 +: 8] = d[j*8 +: 8];
  endfunction

  function automatic void push_b(logic [AW-1:0] a, logic [IW-1:0] id);
    b_exp_t e;
    e.id   = id;
    e.resp = (SLV && addr_oor(a)) ? 2'b10 : 2'b00;
    bq.push_back(e);
  endfunction

  // Ready generation: random in soak mode, otherwise fixed levels set by the driver
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      bready_i = ($urandom_range(0, 3) != 0);
      rready_i = ($urandom_range(0, 2) != 0);
    end else begin
      bready_i = bready_fix;
      rready_i = rready_fix;
    end
  end

  // B monitor
  always @(negedge clk) begin
    if (areset && bvalid_o) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected actual bid=%0h bresp=%0h required no response", bid_o, bresp_o);
      end else begin
        check("b_resp", {bid_o, bresp_o}, {bq[0].id, bq[0].resp});
        if (bready_i) void'(bq.pop_front());
      end
    end
  end

  // R monitor: compares every cycle rvalid is up, which also covers stability under back-pressure
  always @(negedge clk) begin
    if (areset && rvalid_o) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected actual rid=%0h rdata=%0h required no response", rid_o, rdata_o);
      end else begin
        check("r_beat", {rid_o, rdata_o, rresp_o, rlast_o}, {rq[0].id, rq[0].data, rq[0].resp, 1'b1});
        if (rready_i) void'(rq.pop_front());
      end
    end
  end

  task automatic aw_send(input logic [AW-1:0] a, input logic [IW-1:0] id);
    int n = 0;
    @(posedge clk); #1;
    awaddr_i = a; awid_i = id; awvalid_i = 1'b1;
    @(negedge clk);
    while (!awready_o && n < TMO) begin @(negedge clk); n++; end
    if (!awready_o) begin checks++; errors++; $display("FAIL aw_timeout actual awready=0 required 1"); end
    @(posedge clk); #1 awvalid_i = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    @(posedge clk); #1;
    wdata_i = d; wstrb_i = s; wlast_i = 1'b1; wvalid_i = 1'b1;
    @(negedge clk);
    while (!wready_o && n < TMO) begin @(negedge clk); n++; end
    if (!wready_o) begin checks++; errors++; $display("FAIL w_timeout actual wready=0 required 1"); end
    @(posedge clk); #1 wvalid_i = 1'b0;
  endtask

  task automatic ar_send(input logic [AW-1:0] a, input logic [IW-1:0] id);
    int n = 0;
    r_exp_t e;
    e.id   = id;
    e.data = (SLV && addr_oor(a)) ? '0 : mdl[addr_idx(a)];
    e.resp = (SLV && addr_oor(a)) ? 2'b10 : 2'b00;
    rq.push_back(e);
    @(posedge clk); #1;
    araddr_i = a; arid_i = id; arvalid_i = 1'b1;
    @(negedge clk);
    while (!arready_o && n < TMO) begin @(negedge clk); n++; end
    if (!arready_o) begin checks++; errors++; $display("FAIL ar_timeout actual arready=0 required 1"); end
    @(posedge clk); #1 arvalid_i = 1'b0;
  endtask

  task automatic check_regs(input string name);
    logic [NR*DW-1:0] f;
    @(negedge clk);
    for (int k = 0; k < int'(NR); k++) f[k*DW +: DW] = mdl[k];
    check(name, regs_o, f);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [IW-1:0] id,
                          input logic [DW-1:0] d, input logic [SW-1:0] s, input int order);
    push_b(a, id);
    case (order)
      0: fork aw_send(a, id); w_send(d, s); join
      1: begin w_send(d, s); aw_send(a, id); end
      default: begin aw_send(a, id); w_send(d, s); end
    endcase
    model_write(a, d, s);
    check_regs("regs_after_write");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < TMO) begin @(negedge clk); n++; end
    if (bq.size() != 0 || rq.size() != 0) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual pending b=%0d r=%0d required 0", bq.size(), rq.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    areset = 1'b0;
    awid_i = '0; awaddr_i = '0; awvalid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
    arid_i = '0; araddr_i = '0; arvalid_i = 1'b0;
    for (int k = 0; k < int'(NR); k++) mdl[k] = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b1;
    @(negedge clk);
    check("rst_ready", {awready_o, wready_o, arready_o}, 3'b111);
    check("rst_valid", {bvalid_o, rvalid_o}, 2'b00);
    check("rst_payload", {bid_o, bresp_o, rid_o, rdata_o, rresp_o, rlast_o}, '0);
    check("rst_regs", regs_o, '0);

    // Reset with an AW held
    do_write(32'h14, 4'd1, 32'hDEADBEEF, 4'hF, 0);
    wait_idle();
    aw_send(32'h0, 4'd2);
    @(negedge clk);
    check("aw_held_ready", {awready_o, wready_o}, 2'b01);
    @(posedge clk); #1 areset = 1'b0;
    for (int k = 0; k < int'(NR); k++) mdl[k] = '0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b1;
    @(negedge clk);
    check("rst2_ready", {awready_o, wready_o}, 2'b11);
    check("rst2_bvalid", bvalid_o, 1'b0);
    check("rst2_regs", regs_o, '0);

    // W before AW; a stale AW hold would commit here
    push_b(32'h8, 4'd3);
    w_send(32'hA5A5A5A5, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wfirst_pending", {bvalid_o, awready_o, wready_o}, 3'b010);
    aw_send(32'h8, 4'd3);
    check("wfirst_bvalid", bvalid_o, 1'b1);
    model_write(32'h8, 32'hA5A5A5A5, 4'hF);
    check_regs("wfirst_regs");
    check("wfirst_reg2", regs_o[95:64], 32'hA5A5A5A5);
    wait_idle();

    // Partial strobe
    do_write(32'h4, 4'd4, 32'h11223344, 4'hF, 2);
    do_write(32'h4, 4'd4, 32'hFFFFFFFF, 4'h6, 0);
    check("strobe_reg1", regs_o[63:32], 32'h11FFFF44);
    wait_idle();

    // Read back-pressure
    do_write(32'h4, 4'd6, 32'h12345678, 4'hF, 0);
    wait_idle();
    rready_fix = 1'b0;
    @(posedge clk); #2;
    ar_send(32'h4, 4'd5);
    repeat (4) @(posedge clk);
    #1 check("bp_rvalid_held", {rvalid_o, rlast_o, rid_o, rdata_o}, {1'b1, 1'b1, 4'd5, 32'h12345678});
    rready_fix = 1'b1;
    wait_idle();

    // Read and write commit to the same register on the same edge
    do_write(32'hC, 4'd7, 32'h1, 4'hF, 0);
    wait_idle();
    push_b(32'hC, 4'd8);
    w_send(32'h2, 4'hF);
    fork
      aw_send(32'hC, 4'd8);
      ar_send(32'hC, 4'd9);
    join
    model_write(32'hC, 32'h2, 4'hF);
    wait_idle();
    ar_send(32'hC, 4'd10);
    wait_idle();
    check("collide_reg3", regs_o[127:96], 32'h2);

    // Out-of-range write and read
    do_write(32'h20, 4'd11, 32'hCAFEF00D, 4'hF, 0);
    check("oor_reg0", regs_o[31:0], SLV ? 32'h0 : 32'hCAFEF00D);
    ar_send(32'h20, 4'd12);
    wait_idle();

    // Randomized traffic with random ready back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a  = AW'($urandom_range(0, 63));
      id = IW'($urandom);
      d  = DW'($urandom);
      s  = SW'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) ar_send(a, id);
      else do_write(a, id, d, s, int'($urandom_range(0, 2)));
    end
    rand_mode = 1'b0;
    wait_idle();
    check("bq_drained", 32'(bq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    check_regs("final_regs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
